// File: rtl/fifo_wr_packer.sv
// Packs narrow valid/ready beats little-endian into WIDTH-bit words for the async FIFO write port.
// A hold register and a two-state FSM feed wr_en/wdata, and writes are gated by fifo_full.
module fifo_wr_packer #(
  parameter int                     WIDTH     = 32,
  parameter int                     IN_WIDTH  = 8,
  parameter logic [IN_WIDTH-1:0]    PAD_VAL   = '0,
  parameter int                     CNT_WIDTH = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 fifo_full,
  output logic                 wr_en,
  output logic [WIDTH-1:0]     wdata,
  output logic [CNT_WIDTH-1:0] words_written,
  output logic [CNT_WIDTH-1:0] frames_written,
  output logic                 stalled
);

  localparam int RATIO = WIDTH / IN_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_LOADED = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_acc;
  logic [LW-1:0]        r_lane;
  logic [WIDTH-1:0]     r_hold_data;
  logic                 r_hold_last;
  logic [CNT_WIDTH-1:0] r_words;
  logic [CNT_WIDTH-1:0] r_frames;

  logic                 w_loaded;
  logic                 w_wr_en;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_lane_top;
  logic                 w_complete;
  logic [WIDTH-1:0]     w_word;

  assign w_loaded   = (r_state == S_LOADED);
  assign w_wr_en    = !rst && w_loaded && !fifo_full;
  assign w_in_ready = !rst && (!w_loaded || !fifo_full);
  assign w_accept   = in_valid && w_in_ready;
  assign w_lane_top = (r_lane == LW'(RATIO - 1));
  assign w_complete = w_accept && (w_lane_top || in_last);

  // Lanes below the current one come from acc, the current lane takes the beat,
  // and lanes above are padded (only visible when a short frame closes the word).
  always_comb begin
    w_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(r_lane)) begin
        w_word[i*IN_WIDTH +: IN_WIDTH] = r_acc[i*IN_WIDTH +: IN_WIDTH];
      end else if (i == int'(r_lane)) begin
        w_word[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end else begin
        w_word[i*IN_WIDTH +: IN_WIDTH] = PAD_VAL;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_acc       <= '0;
      r_lane      <= '0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
      r_words     <= '0;
      r_frames    <= '0;
    end else begin
      if (w_wr_en) begin
        r_words <= r_words + CNT_WIDTH'(1);
        if (r_hold_last) begin
          r_frames <= r_frames + CNT_WIDTH'(1);
        end
      end

      if (w_complete) begin
        // A commit on the same edge still leaves the FSM loaded: no bubble.
        r_hold_data <= w_word;
        r_hold_last <= in_last;
        r_acc       <= '0;
        r_lane      <= '0;
        r_state     <= S_LOADED;
      end else begin
        if (w_accept) begin
          r_acc  <= w_word;
          r_lane <= r_lane + LW'(1);
        end
        if (w_wr_en) begin
          r_state <= S_EMPTY;
        end
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign wr_en          = w_wr_en;
  assign wdata          = (!rst && w_loaded) ? r_hold_data : '0;
  assign words_written  = r_words;
  assign frames_written = r_frames;
  assign stalled        = !rst && w_loaded && fifo_full;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: directed vector table, corner sequences and a
// randomized run against a queue-based reference model; a CNT_WIDTH=4 twin checks counter wrap.
module tb_fifo_wr_packer;

  localparam int RATIO = 4;

  logic        wr_clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        fifo_full;
  logic        in_ready, wr_en, stalled;
  logic [31:0] wdata;
  logic [15:0] words_written, frames_written;
  logic        in_ready_b, wr_en_b, stalled_b;
  logic [31:0] wdata_b;
  logic [3:0]  words_b, frames_b;

  int errors = 0;
  int checks = 0;

  fifo_wr_packer #(.WIDTH(32), .IN_WIDTH(8), .PAD_VAL(8'h00), .CNT_WIDTH(16)) dut (
    .wr_clk(wr_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .fifo_full(fifo_full), .wr_en(wr_en), .wdata(wdata),
    .words_written(words_written), .frames_written(frames_written), .stalled(stalled)
  );

  fifo_wr_packer #(.WIDTH(32), .IN_WIDTH(8), .PAD_VAL(8'h00), .CNT_WIDTH(4)) dut_w (
    .wr_clk(wr_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_b), .fifo_full(fifo_full), .wr_en(wr_en_b), .wdata(wdata_b),
    .words_written(words_b), .frames_written(frames_b), .stalled(stalled_b)
  );

  always #5 wr_clk = ~wr_clk;

  // Reference model: accepted beats of the current word, and words waiting to be committed
  // (bit 32 = frame-closing flag).
  logic [7:0]  m_beats[$];
  logic [32:0] m_q[$];
  int          m_words;
  int          m_frames;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_q.delete();
    m_words  = 0;
    m_frames = 0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model at the negedge,
  // then advance the model across the posedge. Sampled outputs are returned.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f,
                       output logic s_wr, output logic [31:0] s_wd,
                       output logic s_rdy, output logic s_st);
    logic        exp_wr, exp_rdy, exp_st;
    logic [31:0] exp_wd;
    logic [32:0] w;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    fifo_full = f;
    @(negedge wr_clk);
    exp_wr  = !rst && (m_q.size() > 0) && !f;
    exp_rdy = !rst && ((m_q.size() == 0) || !f);
    exp_st  = !rst && (m_q.size() > 0) && f;
    exp_wd  = (!rst && m_q.size() > 0) ? m_q[0][31:0] : 32'h0;
    s_wr = wr_en; s_wd = wdata; s_rdy = in_ready; s_st = stalled;
    chk("wr_en", wr_en, exp_wr);
    chk("in_ready", in_ready, exp_rdy);
    chk("stalled", stalled, exp_st);
    chk("wdata", wdata, exp_wd);
    chk("words_written", words_written, 64'(m_words[15:0]));
    chk("frames_written", frames_written, 64'(m_frames[15:0]));
    chk("wrap_wr_en", wr_en_b, exp_wr);
    chk("wrap_wdata", wdata_b, exp_wd);
    chk("wrap_words", words_b, 64'(m_words[3:0]));
    chk("wrap_frames", frames_b, 64'(m_frames[3:0]));
    @(posedge wr_clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_wr) begin
        w = m_q.pop_front();
        m_words++;
        if (w[32]) m_frames++;
      end
      if (v && exp_rdy) begin
        m_beats.push_back(d);
        if (m_beats.size() == RATIO || l) begin
          w = '0;
          for (int k = 0; k < m_beats.size(); k++) w = w | (33'(m_beats[k]) << (8 * k));
          w[32] = l;
          m_q.push_back(w);
          m_beats.delete();
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        f;
    logic        e_wr;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] d, input logic l, input logic f,
                              input logic e_wr, input logic [31:0] e_wd,
                              input logic e_rdy, input logic e_st);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.f = f;
    t.e_wr = e_wr; t.e_wd = e_wd; t.e_rdy = e_rdy; t.e_st = e_st;
    tbl.push_back(t);
  endfunction

  logic        s_wr, s_rdy, s_st;
  logic [31:0] s_wd;

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; fifo_full = 0;
    model_reset();
    #1;
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("reset_in_ready", s_rdy, 0);
    chk("reset_wr_en", s_wr, 0);
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    rst = 1'b0;
    chk("reset_words", words_written, 0);
    chk("reset_frames", frames_written, 0);
    chk("reset_wdata", wdata, 0);

    // basic pack
    add(1, 8'h11, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h22, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h33, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h44, 0, 0, 0, 32'h0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 32'h44332211, 1, 0);
    // short frame, padded
    add(1, 8'hAA, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'hBB, 1, 0, 0, 32'h0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 32'h0000BBAA, 1, 0);
    // back-pressure
    add(1, 8'h11, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h22, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h33, 0, 0, 0, 32'h0, 1, 0);
    add(1, 8'h44, 0, 0, 0, 32'h0, 1, 0);
    add(0, 8'h00, 0, 1, 0, 32'h44332211, 0, 1);
    add(0, 8'h00, 0, 1, 0, 32'h44332211, 0, 1);
    add(1, 8'h55, 0, 1, 0, 32'h44332211, 0, 1);
    add(0, 8'h00, 0, 0, 1, 32'h44332211, 1, 0);
    add(0, 8'h00, 0, 0, 0, 32'h0, 1, 0);
    // streaming
    for (int i = 0; i < 8; i++)
      add(1, 8'(i), 0, 0, (i == 4), (i == 4) ? 32'h03020100 : 32'h0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 32'h07060504, 1, 0);
    // single-beat frames back to back: commit and reload on the same edge
    add(1, 8'h01, 1, 0, 0, 32'h0, 1, 0);
    add(1, 8'h02, 1, 0, 1, 32'h00000001, 1, 0);
    add(0, 8'h00, 0, 0, 1, 32'h00000002, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, s_wr, s_wd, s_rdy, s_st);
      chk($sformatf("tbl_wr_en[%0d]", i), s_wr, tbl[i].e_wr);
      chk($sformatf("tbl_wdata[%0d]", i), s_wd, tbl[i].e_wd);
      chk($sformatf("tbl_in_ready[%0d]", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl_stalled[%0d]", i), s_st, tbl[i].e_st);
    end
    chk("tbl_words", words_written, 7);
    chk("tbl_frames", frames_written, 3);

    // reset mid-word discards the partial word
    cycle(1, 8'h01, 0, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(1, 8'h02, 0, 0, s_wr, s_wd, s_rdy, s_st);
    rst = 1'b1;
    cycle(1, 8'h03, 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("rst_in_ready", s_rdy, 0);
    rst = 1'b0;
    chk("rst_words", words_written, 0);
    chk("rst_frames", frames_written, 0);
    for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("rst_words_pre", words_written, 0);
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("rst_word_wr", s_wr, 1);
    chk("rst_word_data", s_wd, 32'h08070605);
    chk("rst_words_post", words_written, 1);

    // in_last on the top lane: no padding, word closes a frame
    cycle(1, 8'hA1, 0, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(1, 8'hA2, 0, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(1, 8'hA3, 0, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(1, 8'hA4, 1, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("toplast_data", s_wd, 32'hA4A3A2A1);
    chk("toplast_frames", frames_written, 1);

    // counter wrap: 17 words on the 4-bit twin
    rst = 1'b1;
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    rst = 1'b0;
    for (int i = 0; i < 17 * RATIO; i++) cycle(1, 8'(i), 0, 0, s_wr, s_wd, s_rdy, s_st);
    cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);
    chk("wrap_words4", words_b, 1);
    chk("wrap_words16", words_written, 17);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, s_wr, s_wd, s_rdy, s_st);
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) cycle(0, 8'h00, 0, 0, s_wr, s_wd, s_rdy, s_st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side feeder for the asynchronous FIFO, running entirely in the `wr_clk` domain. It accepts narrow beats over a valid/ready handshake and packs them little-endian into `WIDTH`-bit words. Frames ending with `in_last` are padded to a full word. Completed words are driven into the FIFO's `wr_en`/`wdata`, gated by the FIFO's `full`, so the FIFO never overflows.

## Interface
- `WIDTH`, 32: FIFO word width; must equal the FIFO's `WIDTH`.
- `IN_WIDTH`, 8: input beat width; `WIDTH % IN_WIDTH == 0` is required.
- `PAD_VAL`, 0: `IN_WIDTH`-bit value placed in unfilled lanes when a frame is padded.
- `CNT_WIDTH`, 16: width of the status counters.
- Derived: `RATIO = WIDTH/IN_WIDTH`, range ≥ 1. `LW = max(1, clog2(RATIO))`.

Ports (name, direction, width, meaning):
- `wr_clk`  in  1  write-domain clock; shared with the FIFO write side.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  IN_WIDTH  beat data.
- `in_last`  in  1  beat is the final beat of a frame.
- `in_ready`  out  1  beat accepted on a posedge where `in_valid && in_ready`.
- `fifo_full`  in  1  the FIFO's `full` output.
- `wr_en`  out  1  FIFO write strobe.
- `wdata`  out  WIDTH  FIFO write data.
- `words_written`  out  CNT_WIDTH  count of words committed to the FIFO; wraps.
- `frames_written`  out  CNT_WIDTH  count of committed words that closed a frame; wraps.
- `stalled`  out  1  hold register is valid and `fifo_full` is high.

## Operation
- State:
  - accumulator `acc[WIDTH-1:0]`
  - lane counter `lane[LW-1:0]`, range 0..RATIO-1
  - hold register `hold_data`, with `hold_last`
  - 2-state FSM: `EMPTY` (no hold) and `LOADED` (hold valid)
- Reset: every output is 0 (`in_ready`, `wr_en`, `wdata`, both counters, `stalled`), and `acc`, `lane` and the FSM (`EMPTY`) are cleared. While `rst` is high, `in_ready=0` and `wr_en=0`.
- Combinational outputs:
  - `wr_en = LOADED && !fifo_full`
  - `wdata = hold_data`, which is 0 in `EMPTY`
  - `in_ready = !rst && (EMPTY || !fifo_full)`
- Accepted beat: `in_data` is written into lane `lane`, bits `[lane*IN_WIDTH +: IN_WIDTH]`. The first beat of a word occupies the LSBs.
- Word completion happens when `lane==RATIO-1` or `in_last=1`:
  - The full word is moved into hold; lanes above `lane` are filled with `PAD_VAL`.
  - `hold_last` takes the value of `in_last`.
  - `lane` returns to 0 and `acc` is cleared.
  - The FSM goes to `LOADED`.
- A non-completing beat sets `lane` to `lane+1`; the FSM state is unchanged.
- FSM transitions:
  - `EMPTY` → `LOADED` on word completion.
  - `LOADED` → `EMPTY` when `wr_en` is high and no completion occurs on the same edge.
  - `LOADED` → `LOADED` when `wr_en` and a completion occur on the same edge: the hold is reloaded with no bubble.
  - `LOADED` with `fifo_full` high: hold, `acc` and `lane` are frozen and no beats are accepted.
- Counters, on each edge with `wr_en` high:
  - `words_written` increments by 1.
  - `frames_written` increments by 1 if `hold_last` is set.
  - Both wrap modulo 2^CNT_WIDTH.
- `RATIO==1`: every beat completes a word, and no padding is ever applied.
- `in_last` when `lane==RATIO-1`: no pad lanes; the word is flagged `last`.

## Timing
- Completing beat accepted at edge N: hold is valid after N. With `fifo_full` low, `wr_en=1` in cycle N..N+1 and the FIFO commits at edge N+1. This is one cycle of latency.
- Sustained throughput: one word per RATIO accepted beats. `in_ready` stays at 1 as long as `fifo_full` stays low.
- `fifo_full` rising: `wr_en` drops in the same cycle (combinational). `wdata` stays stable until the commit.
- `fifo_full` falling: the commit happens at the next edge. `stalled` tracks `LOADED && fifo_full` combinationally.
- `rst` asserted mid-word or mid-stall: all state is discarded at that edge. The partial word and the hold are lost and never written.

## Test plan
Configuration for all scenarios: `WIDTH=32`, `IN_WIDTH=8`, `PAD_VAL=0`.

- **Basic pack:** beats 0x11, 0x22, 0x33, 0x44 back-to-back, `fifo_full=0` → one-cycle `wr_en` pulse the cycle after the 4th beat, `wdata=0x44332211`, `words_written=1`.
- **Short frame:** beats 0xAA, then 0xBB with `in_last=1` → `wdata=0x0000BBAA`, `words_written=1`, `frames_written=1`.
- **Back-pressure:** hold loaded with 0x44332211, `fifo_full=1` for 10 cycles → `wr_en=0`, `in_ready=0`, `stalled=1`, `wdata` stable. Drop `fifo_full` → exactly one write at the next edge.
- **Streaming:** 16 beats 0x00..0x0F continuous, `fifo_full=0` → 4 writes: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. `in_ready` never drops; reload with no bubble.
- **Reset mid-word:** 2 beats 0x01, 0x02, then 1 cycle of `rst`, then beats 0x05..0x08 → single word 0x08070605. Counters are 0 before the post-reset word is written.
- **Counter wrap:** `CNT_WIDTH=4`, 17 full words → `words_written=1`.
